// File: rtl/div_unit_if.sv
// Operand/result bundle for div_unit.
//   a, b      : signed dividend / divisor (driven by master)
//   init      : start request
//   stop      : synchronous abort
//   hi, lo    : remainder / quotient registers (driven by slave)
//   busy      : division in progress
//   done      : one-cycle result/error pulse
//   div_zero  : one-cycle pulse with done when the divisor was zero
interface div_unit_if #(
    parameter int unsigned NBITS = 32
);
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic             init;
    logic             stop;
    logic [NBITS-1:0] hi;
    logic [NBITS-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output a, b, init, stop,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  a, b, init, stop,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Signed restoring divider, one quotient bit per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : div_unit_if slave (operands, init/stop, hi/lo results, status)
// Result truncates toward zero; remainder carries the dividend's sign.
module div_unit #(
    parameter int unsigned NBITS = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);

    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_n;
    logic [NBITS-1:0] hi_q, hi_n;
    logic [NBITS-1:0] lo_q, lo_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             dz_q, dz_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [NBITS-1:0] rem_q, rem_n;
    logic [NBITS-1:0] quot_q, quot_n;
    logic [NBITS-1:0] dvs_q, dvs_n;
    logic             neg_r_q, neg_r_n;
    logic             neg_q_q, neg_q_n;

    logic [NBITS-1:0] a_abs;
    logic [NBITS-1:0] b_abs;
    logic [NBITS:0]   shifted;
    logic             ge;

    // Operand magnitudes; 0x80000000 maps to itself, which is correct unsigned
    assign a_abs = bus.a[NBITS-1] ? (~bus.a + NBITS'(1)) : bus.a;
    assign b_abs = bus.b[NBITS-1] ? (~bus.b + NBITS'(1)) : bus.b;

    // One restoring step: 33-bit partial remainder compared against |b|
    assign shifted = {rem_q, quot_q[NBITS-1]};
    assign ge      = (shifted >= {1'b0, dvs_q});

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvs_q   <= '0;
            neg_r_q <= 1'b0;
            neg_q_q <= 1'b0;
        end else begin
            state_q <= state_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            dz_q    <= dz_n;
            cnt_q   <= cnt_n;
            rem_q   <= rem_n;
            quot_q  <= quot_n;
            dvs_q   <= dvs_n;
            neg_r_q <= neg_r_n;
            neg_q_q <= neg_q_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n = state_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        dz_n    = 1'b0;
        cnt_n   = cnt_q;
        rem_n   = rem_q;
        quot_n  = quot_q;
        dvs_n   = dvs_q;
        neg_r_n = neg_r_q;
        neg_q_n = neg_q_q;

        case (state_q)
            IDLE: begin
                if (bus.init) begin
                    rem_n   = '0;
                    quot_n  = a_abs;
                    dvs_n   = b_abs;
                    neg_r_n = bus.a[NBITS-1];
                    neg_q_n = bus.a[NBITS-1] ^ bus.b[NBITS-1];
                    if (bus.b == '0) begin
                        // Error posts immediately; hi/lo keep their old values
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        dz_n    = 1'b1;
                    end else begin
                        state_n = RUN;
                        busy_n  = 1'b1;
                        cnt_n   = CNT_W'(NBITS);
                    end
                end
            end
            RUN: begin
                rem_n  = ge ? (shifted[NBITS-1:0] - dvs_q) : shifted[NBITS-1:0];
                quot_n = {quot_q[NBITS-2:0], ge};
                cnt_n  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                lo_n    = neg_q_q ? (~quot_q + NBITS'(1)) : quot_q;
                hi_n    = neg_r_q ? (~rem_q + NBITS'(1)) : rem_q;
                state_n = DONE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort wins over everything, including a same-edge init
        if (bus.stop) begin
            state_n = IDLE;
            hi_n    = '0;
            lo_n    = '0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            dz_n    = 1'b0;
            cnt_n   = '0;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: table of directed divisions plus
// hand-written sequences for divide-by-zero, ignored init, stop and reset.
module tb_div_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    div_unit_if #(.NBITS(32)) bus ();

    div_unit #(.NBITS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive operands and init; returns just after capture edge k
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
        bus.a    = av;
        bus.b    = bv;
        bus.init = 1'b1;
        @(posedge clk);
        #1;
        bus.init = 1'b0;
        bus.a    = $urandom;
        bus.b    = $urandom;
    endtask

    // Count edges until done; busy must stay high until then
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    int   lat;
    logic bok;
    int   pulses;

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = '{32'd7,        32'd2,        32'd3,        32'd1};
        vecs[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        vecs[4]  = '{32'd100,      32'd7,        32'd14,       32'd2};
        vecs[5]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE};
        vecs[6]  = '{32'd0,        32'd5,        32'd0,        32'd0};
        vecs[7]  = '{32'd5,        32'd7,        32'd0,        32'd5};
        vecs[8]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0};
        vecs[9]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0};
        vecs[10] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0};
        vecs[11] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF};

        rst      = 1'b0;
        bus.a    = '0;
        bus.b    = '0;
        bus.init = 1'b0;
        bus.stop = 1'b0;
        #12;
        check("rst_hi",   bus.hi, 32'd0);
        check("rst_lo",   bus.lo, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dz",   32'(bus.div_zero), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Table-driven divisions
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy_k", i), 32'(bus.busy), 32'd1);
            wait_done(lat, bok);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'd33);
            check($sformatf("v%0d_busy_run", i), 32'(bok), 32'd1);
            check($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
            check($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
            check($sformatf("v%0d_dz", i), 32'(bus.div_zero), 32'd0);
            check($sformatf("v%0d_busy_done", i), 32'(bus.busy), 32'd0);
            // init during DONE must be ignored
            bus.a    = 32'd9;
            bus.b    = 32'd3;
            bus.init = (i == 0);
            @(posedge clk);
            #1;
            bus.init = 1'b0;
            check($sformatf("v%0d_done_1cyc", i), 32'(bus.done), 32'd0);
            check($sformatf("v%0d_busy_idle", i), 32'(bus.busy), 32'd0);
            check($sformatf("v%0d_lo_hold", i), bus.lo, vecs[i].lo);
        end

        // Preload hi=1, lo=3 then divide by zero
        start_op(32'd7, 32'd2);
        wait_done(lat, bok);
        @(posedge clk);
        #1;
        start_op(32'd5, 32'd0);
        check("dz_done",  32'(bus.done), 32'd1);
        check("dz_flag",  32'(bus.div_zero), 32'd1);
        check("dz_busy",  32'(bus.busy), 32'd0);
        check("dz_hi",    bus.hi, 32'd1);
        check("dz_lo",    bus.lo, 32'd3);
        @(posedge clk);
        #1;
        check("dz_done_off", 32'(bus.done), 32'd0);
        check("dz_flag_off", 32'(bus.div_zero), 32'd0);
        check("dz_hi_hold",  bus.hi, 32'd1);

        // Second init mid-run must not disturb 100/7
        start_op(32'd100, 32'd7);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        bus.a    = 32'd1;
        bus.b    = 32'd1;
        bus.init = 1'b1;
        @(posedge clk);
        #1;
        bus.init = 1'b0;
        wait_done(lat, bok);
        check("reinit_lat",  32'(lat), 32'd28);
        check("reinit_busy", 32'(bok), 32'd1);
        check("reinit_lo",   bus.lo, 32'd14);
        check("reinit_hi",   bus.hi, 32'd2);
        @(posedge clk);
        #1;

        // Init at k+5 then stop at k+10
        start_op(32'd100, 32'd7);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        bus.init = 1'b1;
        @(posedge clk);
        #1;
        bus.init = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        check("stop_pre_busy", 32'(bus.busy), 32'd1);
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.stop = 1'b0;
        check("stop_hi",   bus.hi, 32'd0);
        check("stop_lo",   bus.lo, 32'd0);
        check("stop_busy", 32'(bus.busy), 32'd0);
        check("stop_done", 32'(bus.done), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) pulses++;
        end
        check("stop_quiet", 32'(pulses), 32'd0);

        // stop beats a simultaneous init, and clears held results
        start_op(32'd7, 32'd2);
        wait_done(lat, bok);
        @(posedge clk);
        #1;
        bus.a    = 32'd100;
        bus.b    = 32'd7;
        bus.init = 1'b1;
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.init = 1'b0;
        bus.stop = 1'b0;
        check("prio_busy", 32'(bus.busy), 32'd0);
        check("prio_hi",   bus.hi, 32'd0);
        check("prio_lo",   bus.lo, 32'd0);

        // Asynchronous reset mid-run
        start_op(32'd100, 32'd7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_hi",   bus.hi, 32'd0);
        check("arst_lo",   bus.lo, 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        start_op(32'd100, 32'd7);
        check("post_rst_busy", 32'(bus.busy), 32'd1);
        wait_done(lat, bok);
        check("post_rst_lat", 32'(lat), 32'd33);
        check("post_rst_lo",  bus.lo, 32'd14);
        check("post_rst_hi",  bus.hi, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have one parameter: NBITS, default 32, the operand and result width; only 32 is required to be supported.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port a, input, 32 bits: signed dividend.
REQ-005 SHALL have port b, input, 32 bits: signed divisor.
REQ-006 SHALL have port init, input, 1 bit: start request, sampled at rising clk.
REQ-007 SHALL have port stop, input, 1 bit: synchronous abort, sampled at rising clk.
REQ-008 SHALL have port hi, output, 32 bits: remainder register.
REQ-009 SHALL have port lo, output, 32 bits: quotient register.
REQ-010 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a result or error is posted.
REQ-012 SHALL have port div_zero, output, 1 bit: one-cycle pulse, coincident with done, when b was 0.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN, FIX and DONE.
REQ-014 In IDLE, init=1 at edge k SHALL capture |a|, |b|, sign(a) and sign(a) XOR sign(b), set busy at edge k, and enter RUN with a 6-bit iteration counter set to 32.
REQ-015 If b==0 at capture edge k, the FSM SHALL go to DONE instead of RUN; hi and lo SHALL remain unchanged; done=1 and div_zero=1 SHALL be asserted during cycle k+1.
REQ-016 RUN SHALL perform one restoring-division step per cycle, shifting {rem, quot} left by 1, subtracting |b| from the 33-bit partial remainder, restoring it when the result is negative, and setting the quotient bit when it is not; the counter SHALL decrement each step.
REQ-017 After 32 steps (edges k+1..k+32), the FSM SHALL enter FIX; at edge k+33 it SHALL write lo = quotient (negated if the sign XOR is set) and hi = remainder (negated if the dividend was negative), then enter DONE.
REQ-018 The result SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign, or be zero.
REQ-019 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0 with no error flag (natural wrap).
REQ-020 DONE SHALL last exactly one cycle, with done=1 and busy=0, then return to IDLE; init sampled during DONE SHALL be ignored.
REQ-021 init asserted while busy=1 SHALL be ignored; the running operation SHALL continue unaffected.
REQ-022 stop=1 at any edge SHALL force IDLE and clear hi, lo, busy, done, div_zero and the counter to 0; stop SHALL take priority over a simultaneous init.
REQ-023 hi and lo SHALL hold their last value in IDLE until the next FIX write, stop, or reset.
REQ-024 Operand changes on a and b after the capture edge SHALL NOT affect the result.

Reset
REQ-025 rst=0 SHALL immediately, without a clock, force IDLE and set hi=0, lo=0, busy=0, done=0, div_zero=0 and all internal registers to 0, including during RUN.
REQ-026 After rst returns high, the first init SHALL be accepted at the first rising clk.

Verification
REQ-027 a=7, b=2, init pulse at edge k -> busy during k..k+32; at k+33 lo=3, hi=1; done=1 for exactly one cycle.
REQ-028 a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
REQ-029 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-030 Preload hi=1, lo=3 from the first test, then a=5, b=0 -> done=1 and div_zero=1 in cycle k+1; hi=1 and lo=3 unchanged; busy=0 from k+1.
REQ-031 Start 100/7, pulse init again at k+5, then stop at k+10 -> the second init has no effect; after the stop edge hi=lo=0, busy=0, and done never pulses.
REQ-032 Start 100/7, drive rst=0 asynchronously mid-RUN -> all outputs are 0 before the next clk edge; after release, 100/7 gives lo=14, hi=2 at k+33.
